// File: rtl/minirv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   - FUNCT3_* : RV32M operation encodings carried on funct3
//   - md_state_e : IDLE/CALC/FIX/DONE control states of muldiv_unit
//   - XLEN_DEF / ADDR_W_DEF : default operand and register address widths
//   - helper functions classifying which operands are treated as signed
package minirv_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Operand A is signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
               (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
    endfunction

    // Operand B is signed for MULH, DIV and REM (MULHSU keeps B unsigned).
    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/negate_32bits.sv
// Combinational conditional two's-complement negate.
// Ports:
//   val_i  WIDTH  input value
//   neg_i  1      when high, output is -val_i; otherwise val_i passes through
//   res_o  WIDTH  result
// WIDTH defaults to 32; the product sign fix uses a 64-bit instance.
module negate_32bits #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register file write port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, accepted only in IDLE when kill is low
//   funct3            RV32M operation (MUL..REMU)
//   rs1_val, rs2_val  operand A (multiplicand/dividend), operand B
//   dst_addr          destination register for the result
//   kill              abort any in-flight operation (pipeline flush)
//   busy              high from the accepting edge until the write edge
//   rd_data, rd_addr  result and destination, registered
//   reg_write         one-cycle write strobe
// Optional feature macro: MULDIV_EARLY_OUT_EN -- when defined, an operand of
// zero skips CALC and the write strobe appears two edges after acceptance.
// Without it latency is always XLEN+2 edges.
//
// Flow: IDLE -> CALC (XLEN steps on unsigned magnitudes in a 2*XLEN
// accumulator) -> FIX (sign correction, word select, special cases) ->
// DONE -> IDLE. The outputs are registered from DONE, so the strobe is seen
// in the cycle after the DONE->IDLE edge, the same edge busy drops.
module muldiv_unit
    import minirv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              kill,
    output logic              busy,
    output logic [XLEN-1:0]   rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              reg_write
);

    localparam int CW = $clog2(XLEN);

    md_state_e           state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_q, b_d;          // multiplicand or divisor magnitude
    logic [XLEN-1:0]     a_raw_q, a_raw_d;  // original A, the REM-by-zero result
    logic [2:0]          f_q, f_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                res_neg_q, res_neg_d;
    logic                divzero_q, divzero_d;
    logic                ovf_q, ovf_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                reg_write_q, reg_write_d;

    // Operand magnitudes for the incoming request.
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg = a_is_signed(funct3) & rs1_val[XLEN-1];
    assign b_neg = b_is_signed(funct3) & rs2_val[XLEN-1];

    negate_32bits #(.WIDTH(XLEN)) u_neg_a (.val_i(rs1_val), .neg_i(a_neg), .res_o(a_mag));
    negate_32bits #(.WIDTH(XLEN)) u_neg_b (.val_i(rs2_val), .neg_i(b_neg), .res_o(b_mag));

    // One multiply step: add multiplicand into the high half when the
    // multiplier LSB (accumulator bit 0) is set, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring divide step. The partial remainder shifted left needs
    // XLEN+1 bits, so the trial subtract takes the top XLEN+1 accumulator
    // bits; the extra MSB of the difference is the borrow.
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_step;
    assign div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b0, b_q};
    assign div_step = div_diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Sign correction and result selection. Divide results are zero-extended
    // before the shared 2*XLEN negate; only the low word is used for them.
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        fix_in = acc_q;
        if (f_q[2]) begin
            fix_in = f_q[1] ? {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                            : {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        end
    end

    negate_32bits #(.WIDTH(2*XLEN)) u_neg_res (.val_i(fix_in), .neg_i(res_neg_q), .res_o(fix_out));

    always_comb begin
        if (f_q[2] || (f_q == FUNCT3_MUL)) begin
            fix_res = fix_out[XLEN-1:0];
        end else begin
            fix_res = fix_out[2*XLEN-1:XLEN];
        end
        if (f_q[2] && divzero_q) begin
            fix_res = f_q[1] ? a_raw_q : {XLEN{1'b1}};
        end else if (f_q[2] && ovf_q) begin
            fix_res = f_q[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        b_d         = b_q;
        a_raw_d     = a_raw_q;
        f_d         = f_q;
        dst_d       = dst_q;
        res_neg_d   = res_neg_q;
        divzero_d   = divzero_q;
        ovf_d       = ovf_q;
        res_d       = res_q;
        rd_data_d   = rd_data_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    state_d   = CALC;
                    count_d   = CW'(XLEN - 1);
                    f_d       = funct3;
                    dst_d     = dst_addr;
                    a_raw_d   = rs1_val;
                    divzero_d = (rs2_val == '0);
                    ovf_d     = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                                (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                                (rs2_val == {XLEN{1'b1}});
                    // Remainder takes the dividend's sign; everything else
                    // takes the xor of the operand signs.
                    res_neg_d = (funct3 == FUNCT3_REM) ? a_neg : (a_neg ^ b_neg);
                    if (funct3[2]) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        b_d   = b_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_mag};
                        b_d   = a_mag;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    // A zero accumulator yields 0 for every multiply and for
                    // 0/B; divide-by-zero is overridden in FIX regardless.
                    if ((rs1_val == '0) || (rs2_val == '0)) begin
                        state_d = FIX;
                        acc_d   = '0;
                    end
`endif
                end
            end
            CALC: begin
                acc_d   = f_q[2] ? div_step : mul_step;
                count_d = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d   = fix_res;
                state_d = DONE;
            end
            DONE: begin
                reg_write_d = 1'b1;
                rd_data_d   = res_q;
                rd_addr_d   = dst_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush anywhere past IDLE abandons the op, including its write.
        if (kill && (state_q != IDLE)) begin
            state_d     = IDLE;
            reg_write_d = 1'b0;
            rd_data_d   = rd_data_q;
            rd_addr_d   = rd_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            a_raw_q     <= '0;
            f_q         <= '0;
            dst_q       <= '0;
            res_neg_q   <= 1'b0;
            divzero_q   <= 1'b0;
            ovf_q       <= 1'b0;
            res_q       <= '0;
            rd_data_q   <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            a_raw_q     <= a_raw_d;
            f_q         <= f_d;
            dst_q       <= dst_d;
            res_neg_q   <= res_neg_d;
            divzero_q   <= divzero_d;
            ovf_q       <= ovf_d;
            res_q       <= res_d;
            rd_data_q   <= rd_data_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rd_data   = rd_data_q;
    assign rd_addr   = rd_addr_q;
    assign reg_write = reg_write_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, start/kill/reset
// corner cases, then randomized ops against a plain-arithmetic reference.
module tb_muldiv_unit;

    localparam int LAT_FULL  = 34;
    localparam int LAT_EARLY = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  dst_addr;
    logic        kill;
    logic        busy;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic        reg_write;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    logic [31:0] exp_q[$];

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .dst_addr  (dst_addr),
        .kill      (kill),
        .busy      (busy),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .reg_write (reg_write)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_write) wr_cnt++;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sp;
        logic [63:0] up;
        int          sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'b000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'b001: begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
            3'b010: begin sp = longint'(sa) * longint'({32'b0, b}); up = sp; return up[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 0 || b == 0) return LAT_EARLY;
`endif
        return LAT_FULL;
    endfunction

    // ---------------- drivers ----------------
    // Returns just after the accepting edge E0.
    task automatic issue_start(input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] dst);
        @(negedge clk);
        start    = 1'b1;
        funct3   = f;
        rs1_val  = a;
        rs2_val  = b;
        dst_addr = dst;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until the strobe is seen; checks data/addr/latency
    // and that the strobe lasts one cycle with busy already low.
    task automatic wait_write(input string tag, input logic [4:0] dst, input int lat);
        int n;
        logic [31:0] exp;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (reg_write) begin
                n = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, n, lat);
        if (n == 0) return;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check_eq({tag, "_data"}, rd_data, exp);
        check_eq({tag, "_addr"}, {27'b0, rd_addr}, {27'b0, dst});
        check_eq({tag, "_busy_at_wr"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_strobe_1cyc"}, {31'b0, reg_write}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dst);
        exp_q.push_back(ref_result(f, a, b));
        issue_start(f, a, b, dst);
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_write(tag, dst, exp_latency(a, b));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            4:       return 32'hFFFF_FFFF - $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = '0; rs1_val = '0; rs2_val = '0; dst_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_wr", {31'b0, reg_write}, 32'd0);
        check_eq("rst_data", rd_data, 32'd0);
        check_eq("rst_addr", {27'b0, rd_addr}, 32'd0);

        // Directed arithmetic cases
        run_op("mul",      3'b000, 32'd7,         32'hFFFF_FFFD, 5'd3);
        run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4);
        run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,         5'd6);
        run_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7);
        run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op("divu_z",   3'b101, 32'd100,       32'd0,         5'd11);
        run_op("remu_z",   3'b111, 32'd100,       32'd0,         5'd12);
        run_op("div_z",    3'b100, 32'hFFFF_FFF9, 32'd0,         5'd13);
        run_op("mul_zero", 3'b000, 32'd0,         32'd5,         5'd0);
        run_op("div_a0",   3'b100, 32'd0,         32'd9,         5'd14);

        // Second start while busy is ignored: one write, first op's result
        base = wr_cnt;
        exp_q.push_back(ref_result(3'b000, 32'd1234, 32'd5678));
        issue_start(3'b000, 32'd1234, 32'd5678, 5'd15);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1_val = 32'd99; rs2_val = 32'd3; dst_addr = 5'd16;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_write("dbl_start", 5'd15, LAT_FULL - 5);
        repeat (40) @(posedge clk);
        #1;
        check_eq("dbl_start_wrcnt", wr_cnt - base, 32'd1);

        // Kill mid-CALC
        base = wr_cnt;
        issue_start(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check_eq("kill_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("kill_wrcnt", wr_cnt - base, 32'd0);
        run_op("after_kill", 3'b110, 32'd1000, 32'd7, 5'd18);

        // Kill in DONE suppresses the write
        base = wr_cnt;
        issue_start(3'b000, 32'd3, 32'd3, 5'd19);
        repeat (LAT_FULL - 1) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check_eq("kill_done_wr", {31'b0, reg_write}, 32'd0);
        check_eq("kill_done_busy", {31'b0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("kill_done_wrcnt", wr_cnt - base, 32'd0);

        // Kill with start in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check_eq("kill_start_busy", {31'b0, busy}, 32'd0);

        // Reset mid-DIV: no write, outputs cleared
        base = wr_cnt;
        issue_start(3'b100, 32'd77777, 32'd13, 5'd20);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rstmid_busy", {31'b0, busy}, 32'd0);
        check_eq("rstmid_wr", {31'b0, reg_write}, 32'd0);
        check_eq("rstmid_data", rd_data, 32'd0);
        check_eq("rstmid_addr", {27'b0, rd_addr}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("rstmid_wrcnt", wr_cnt - base, 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            logic [4:0]  d;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            d = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, d);
        end

        check_eq("exp_q_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
